// File: rtl/spi_avmm_responder_pkg.sv
// Shared definitions for the SPI-to-Avalon-MM responder: FSM states,
// header field positions, turnaround default and the failed-read word.
package llrf_afe_package;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        WDATA,
        AV_WR,
        TURN,
        AV_RD,
        RDATA,
        DONE
    } state_t;

    localparam int          HDR_BITS          = 16;
    localparam int          HDR_RW_BIT        = 15;
    localparam int          HDR_ADDR_MSB      = 11;
    localparam int          TURN_BITS_DEFAULT = 8;
    localparam logic [31:0] READ_DEAD_WORD    = 32'hDEADBEEF;

endpackage

// File: rtl/spi_avmm_responder_sync_edge.sv
// Two-flop synchronizer for one asynchronous SPI line, with single-clk
// rise and fall pulses derived from the synchronized level.
module spi_sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_async,
    output logic o_rise,
    output logic o_fall
);

    logic [1:0] r_sync;
    logic       r_prev;

    // Synchronize the line and keep one extra stage for edge detection.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sync <= {2{RESET_VAL}};
            r_prev <= RESET_VAL;
        end else begin
            r_sync <= {r_sync[0], i_async};
            r_prev <= r_sync[1];
        end
    end

    assign o_rise = r_sync[1] & ~r_prev;
    assign o_fall = ~r_sync[1] & r_prev;

endmodule

// File: rtl/spi_avmm_responder.sv
// SPI mode-0 responder that turns one 16-bit header frame per chip-select
// period into a single Avalon-MM read or write. Everything runs on clk;
// SCLK/CS/MOSI are oversampled, so SCLK must stay at or below clk/8.
module spi_avmm_responder
    import llrf_afe_package::*;
#(
    parameter int AW        = 12,
    parameter int DW        = 32,
    parameter int TURN_BITS = TURN_BITS_DEFAULT
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          spi_sclk,
    input  logic          spi_cs,
    input  logic          spi_mosi,
    output logic          spi_miso,
    output logic [AW-1:0] av_address,
    output logic          av_write,
    output logic          av_read,
    output logic [DW-1:0] av_writedata,
    input  logic [DW-1:0] av_readdata,
    input  logic          av_waitrequest,
    output logic          frame_err
);

    localparam int             CNT_W     = $clog2(HDR_BITS + TURN_BITS + DW + 1);
    localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(HDR_BITS - 1);
    localparam logic [CNT_W-1:0] WR_LAST  = CNT_W'(HDR_BITS + DW - 1);
    localparam logic [CNT_W-1:0] TURN_END = CNT_W'(HDR_BITS + TURN_BITS);
    localparam logic [CNT_W-1:0] RD_END   = CNT_W'(HDR_BITS + TURN_BITS + DW);
    localparam logic [DW-1:0]  DEAD_WORD = DW'(READ_DEAD_WORD);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [DW-1:0]    r_shift;
    logic [1:0]       r_mosi_sync;
    logic             r_av_read;
    logic             r_av_write;
    logic [AW-1:0]    r_av_address;
    logic [DW-1:0]    r_av_writedata;
    logic             r_miso;
    logic             r_frame_err;
    logic             r_cs_up;

    logic             w_sclk_rise;
    logic             w_sclk_fall;
    logic             w_cs_rise;
    logic             w_cs_fall;
    logic [DW-1:0]    w_shift_in;

    spi_sync_edge #(.RESET_VAL(1'b0)) u_sclk_sync (
        .i_clk     (clk),
        .i_reset_n (reset_n),
        .i_async   (spi_sclk),
        .o_rise    (w_sclk_rise),
        .o_fall    (w_sclk_fall)
    );

    spi_sync_edge #(.RESET_VAL(1'b1)) u_cs_sync (
        .i_clk     (clk),
        .i_reset_n (reset_n),
        .i_async   (spi_cs),
        .o_rise    (w_cs_rise),
        .o_fall    (w_cs_fall)
    );

    // MOSI gets the same two-stage delay as SCLK so it lines up with the rise pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mosi_sync <= 2'b00;
        end else begin
            r_mosi_sync <= {r_mosi_sync[0], spi_mosi};
        end
    end

    assign w_shift_in = {r_shift[DW-2:0], r_mosi_sync[1]};

    // Frame sequencer; r_cnt counts SCLK rising edges since the frame started,
    // and r_cs_up remembers a CS release seen while a bus transfer was pending.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_shift        <= '0;
            r_av_read      <= 1'b0;
            r_av_write     <= 1'b0;
            r_av_address   <= '0;
            r_av_writedata <= '0;
            r_miso         <= 1'b0;
            r_frame_err    <= 1'b0;
            r_cs_up        <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_miso <= 1'b0;
                    if (w_cs_fall) begin
                        r_state     <= HDR;
                        r_cnt       <= '0;
                        r_frame_err <= 1'b0;
                        r_cs_up     <= 1'b0;
                    end
                end
                HDR: begin
                    if (w_cs_rise) begin
                        r_state     <= IDLE;
                        r_frame_err <= 1'b1;
                    end else if (w_sclk_rise) begin
                        r_shift <= w_shift_in;
                        r_cnt   <= r_cnt + CNT_W'(1);
                        if (r_cnt == HDR_LAST) begin
                            r_av_address <= w_shift_in[HDR_ADDR_MSB -: AW];
                            if (w_shift_in[HDR_RW_BIT]) begin
                                r_av_read <= 1'b1;
                                r_state   <= AV_RD;
                            end else begin
                                r_state <= WDATA;
                            end
                        end
                    end
                end
                WDATA: begin
                    if (w_cs_rise) begin
                        r_state     <= IDLE;
                        r_frame_err <= 1'b1;
                    end else if (w_sclk_rise) begin
                        r_shift <= w_shift_in;
                        r_cnt   <= r_cnt + CNT_W'(1);
                        if (r_cnt == WR_LAST) begin
                            r_av_writedata <= w_shift_in;
                            r_av_write     <= 1'b1;
                            r_state        <= AV_WR;
                        end
                    end
                end
                AV_WR: begin
                    if (w_cs_rise) begin
                        r_cs_up <= 1'b1;
                    end
                    if (!av_waitrequest) begin
                        r_av_write <= 1'b0;
                        r_state    <= DONE;
                    end
                end
                AV_RD: begin
                    if (w_sclk_rise) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                    if (w_cs_rise) begin
                        r_cs_up     <= 1'b1;
                        r_frame_err <= 1'b1;
                    end
                    if (!av_waitrequest) begin
                        r_av_read <= 1'b0;
                        if (r_cs_up || w_cs_rise) begin
                            r_state <= IDLE;
                        end else if (w_sclk_fall && (r_cnt == TURN_END)) begin
                            r_miso  <= av_readdata[DW-1];
                            r_shift <= {av_readdata[DW-2:0], 1'b0};
                            r_state <= RDATA;
                        end else begin
                            r_shift <= av_readdata;
                            r_state <= TURN;
                        end
                    end else if (!r_cs_up && !w_cs_rise && w_sclk_fall && (r_cnt == TURN_END)) begin
                        r_av_read   <= 1'b0;
                        r_frame_err <= 1'b1;
                        r_miso      <= DEAD_WORD[DW-1];
                        r_shift     <= {DEAD_WORD[DW-2:0], 1'b0};
                        r_state     <= RDATA;
                    end
                end
                TURN: begin
                    if (w_cs_rise) begin
                        r_state     <= IDLE;
                        r_frame_err <= 1'b1;
                    end else begin
                        if (w_sclk_rise) begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                        if (w_sclk_fall && (r_cnt == TURN_END)) begin
                            r_miso  <= r_shift[DW-1];
                            r_shift <= {r_shift[DW-2:0], 1'b0};
                            r_state <= RDATA;
                        end
                    end
                end
                RDATA: begin
                    if (w_cs_rise) begin
                        r_state <= IDLE;
                        r_miso  <= 1'b0;
                        if (r_cnt != RD_END) begin
                            r_frame_err <= 1'b1;
                        end
                    end else begin
                        if (w_sclk_rise) begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                        if (w_sclk_fall) begin
                            if (r_cnt == RD_END) begin
                                r_miso  <= 1'b0;
                                r_state <= DONE;
                            end else begin
                                r_miso  <= r_shift[DW-1];
                                r_shift <= {r_shift[DW-2:0], 1'b0};
                            end
                        end
                    end
                end
                DONE: begin
                    r_miso <= 1'b0;
                    if (w_cs_rise || r_cs_up) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign spi_miso     = r_miso;
    assign av_address   = r_av_address;
    assign av_write     = r_av_write;
    assign av_read      = r_av_read;
    assign av_writedata = r_av_writedata;
    assign frame_err    = r_frame_err;

endmodule

// File: tb/tb_spi_avmm_responder.sv
// Directed bench for spi_avmm_responder: an SPI host driving mode-0 frames
// at clk/8 and a small Avalon-MM slave with programmable waitrequest.
module tb_spi_avmm_responder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        spi_sclk;
    logic        spi_cs;
    logic        spi_mosi;
    logic        spi_miso;
    logic [11:0] av_address;
    logic        av_write;
    logic        av_read;
    logic [31:0] av_writedata;
    logic [31:0] av_readdata;
    logic        av_waitrequest;
    logic        frame_err;

    int checks   = 0;
    int failures = 0;

    int          waitCycles = 0;
    logic        holdWait   = 1'b0;
    int          waitCnt    = 0;
    int          wrAccepts  = 0;
    int          rdAccepts  = 0;
    int          rdStarts   = 0;
    logic        prevRead   = 1'b0;
    logic [11:0] lastWrAddr = '0;
    logic [31:0] lastWrData = '0;
    logic [11:0] lastRdAddr = '0;

    int          wrBase;
    int          rdBase;
    int          rdStartBase;
    logic [31:0] rx;

    spi_avmm_responder #(.AW(12), .DW(32), .TURN_BITS(8)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .spi_sclk       (spi_sclk),
        .spi_cs         (spi_cs),
        .spi_mosi       (spi_mosi),
        .spi_miso       (spi_miso),
        .av_address     (av_address),
        .av_write       (av_write),
        .av_read        (av_read),
        .av_writedata   (av_writedata),
        .av_readdata    (av_readdata),
        .av_waitrequest (av_waitrequest),
        .frame_err      (frame_err)
    );

    // 100 MHz system clock
    always #5 clk = ~clk;

    // Slave model: stalls each transfer for waitCycles clocks (or forever
    // while holdWait is set) and records every accepted transfer.
    always @(posedge clk) begin
        if (av_read || av_write) waitCnt <= waitCnt + 1;
        else                     waitCnt <= 0;
        if (av_write && !av_waitrequest) begin
            wrAccepts  <= wrAccepts + 1;
            lastWrAddr <= av_address;
            lastWrData <= av_writedata;
        end
        if (av_read && !av_waitrequest) begin
            rdAccepts  <= rdAccepts + 1;
            lastRdAddr <= av_address;
        end
        if (av_read && !prevRead) rdStarts <= rdStarts + 1;
        prevRead <= av_read;
    end

    assign av_waitrequest = holdWait || ((av_read || av_write) && (waitCnt < waitCycles));

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Drives one CS-low period of nbits SCLK cycles (MSB of stream first),
    // collecting the last 32 MISO bits sampled just before each rising edge.
    task automatic applyStimulus(input logic [55:0] stream, input int nbits, output logic [31:0] rxWord);
        rxWord = '0;
        spi_cs = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = stream[55-i];
            repeat (4) @(posedge clk);
            #2;
            rxWord   = {rxWord[30:0], spi_miso};
            spi_sclk = 1'b1;
            repeat (4) @(posedge clk);
            #2;
            spi_sclk = 1'b0;
        end
        spi_mosi = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        spi_cs = 1'b1;
        repeat (8) @(posedge clk);
        #2;
    endtask

    initial begin
        reset_n     = 1'b0;
        spi_sclk    = 1'b0;
        spi_cs      = 1'b1;
        spi_mosi    = 1'b0;
        av_readdata = 32'hCAFE0001;
        repeat (3) @(posedge clk);
        #2;
        checkOutput("rst_av_write", 32'(av_write), 32'h0);
        checkOutput("rst_av_read", 32'(av_read), 32'h0);
        checkOutput("rst_av_address", 32'(av_address), 32'h0);
        checkOutput("rst_av_writedata", av_writedata, 32'h0);
        checkOutput("rst_spi_miso", 32'(spi_miso), 32'h0);
        checkOutput("rst_frame_err", 32'(frame_err), 32'h0);
        reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #2;

        $display("[TB] write 0x123 <= 0xA5A55A5A");
        wrBase = wrAccepts;
        applyStimulus({16'h0123, 32'hA5A55A5A, 8'h00}, 48, rx);
        checkOutput("wr1_count", 32'(wrAccepts - wrBase), 32'd1);
        checkOutput("wr1_addr", 32'(lastWrAddr), 32'h123);
        checkOutput("wr1_data", lastWrData, 32'hA5A55A5A);
        checkOutput("wr1_frame_err", 32'(frame_err), 32'h0);
        checkOutput("wr1_av_write_idle", 32'(av_write), 32'h0);

        $display("[TB] read 0x010 with 3 wait cycles");
        waitCycles  = 3;
        wrBase      = wrAccepts;
        rdBase      = rdAccepts;
        rdStartBase = rdStarts;
        applyStimulus({16'h8010, 40'h0}, 56, rx);
        checkOutput("rd1_miso_word", rx, 32'hCAFE0001);
        checkOutput("rd1_count", 32'(rdAccepts - rdBase), 32'd1);
        checkOutput("rd1_starts", 32'(rdStarts - rdStartBase), 32'd1);
        checkOutput("rd1_addr", 32'(lastRdAddr), 32'h010);
        checkOutput("rd1_no_write", 32'(wrAccepts - wrBase), 32'd0);
        checkOutput("rd1_frame_err", 32'(frame_err), 32'h0);
        checkOutput("rd1_miso_after", 32'(spi_miso), 32'h0);

        $display("[TB] read 0x020 with waitrequest stuck high");
        holdWait    = 1'b1;
        rdBase      = rdAccepts;
        rdStartBase = rdStarts;
        applyStimulus({16'h8020, 40'h0}, 56, rx);
        checkOutput("rd2_miso_word", rx, 32'hDEADBEEF);
        checkOutput("rd2_frame_err", 32'(frame_err), 32'h1);
        checkOutput("rd2_av_read", 32'(av_read), 32'h0);
        checkOutput("rd2_starts", 32'(rdStarts - rdStartBase), 32'd1);
        checkOutput("rd2_count", 32'(rdAccepts - rdBase), 32'd0);
        holdWait   = 1'b0;
        waitCycles = 0;

        $display("[TB] write aborted after 30 SCLK");
        wrBase = wrAccepts;
        applyStimulus({16'h0456, 32'h12345678, 8'h00}, 30, rx);
        checkOutput("abort_no_write", 32'(wrAccepts - wrBase), 32'd0);
        checkOutput("abort_frame_err", 32'(frame_err), 32'h1);
        applyStimulus({16'h0456, 32'h12345678, 8'h00}, 48, rx);
        checkOutput("recover_count", 32'(wrAccepts - wrBase), 32'd1);
        checkOutput("recover_addr", 32'(lastWrAddr), 32'h456);
        checkOutput("recover_data", lastWrData, 32'h12345678);
        checkOutput("recover_frame_err", 32'(frame_err), 32'h0);

        $display("[TB] write with reserved bits set and extra SCLK");
        wrBase = wrAccepts;
        applyStimulus({16'h7ABC, 32'h0F0F0F0F, 8'hFF}, 52, rx);
        checkOutput("rsv_count", 32'(wrAccepts - wrBase), 32'd1);
        checkOutput("rsv_addr", 32'(lastWrAddr), 32'hABC);
        checkOutput("rsv_data", lastWrData, 32'h0F0F0F0F);
        checkOutput("rsv_miso_quiet", rx, 32'h0);
        checkOutput("rsv_frame_err", 32'(frame_err), 32'h0);

        $display("[TB] reset during stalled write");
        holdWait = 1'b1;
        wrBase   = wrAccepts;
        applyStimulus({16'h0321, 32'h13579BDF, 8'h00}, 48, rx);
        checkOutput("stall_av_write", 32'(av_write), 32'h1);
        checkOutput("stall_av_address", 32'(av_address), 32'h321);
        #1;
        reset_n = 1'b0;
        #1;
        checkOutput("mid_rst_av_write", 32'(av_write), 32'h0);
        checkOutput("mid_rst_av_read", 32'(av_read), 32'h0);
        checkOutput("mid_rst_av_address", 32'(av_address), 32'h0);
        checkOutput("mid_rst_av_writedata", av_writedata, 32'h0);
        checkOutput("mid_rst_spi_miso", 32'(spi_miso), 32'h0);
        checkOutput("mid_rst_frame_err", 32'(frame_err), 32'h0);
        repeat (2) @(posedge clk);
        #2;
        reset_n  = 1'b1;
        holdWait = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        checkOutput("mid_rst_no_write", 32'(wrAccepts - wrBase), 32'd0);
        applyStimulus({16'h0654, 32'h2468ACE0, 8'h00}, 48, rx);
        checkOutput("post_rst_count", 32'(wrAccepts - wrBase), 32'd1);
        checkOutput("post_rst_addr", 32'(lastWrAddr), 32'h654);
        checkOutput("post_rst_data", lastWrData, 32'h2468ACE0);
        checkOutput("post_rst_frame_err", 32'(frame_err), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
